// File: rtl/ecc_lockstep_checker.sv
// Lockstep SECDED decode checker: two identical decoders see the same word, their
// flags/correction masks are compared, mismatches fall back to raw data and are counted.

module ecc_secded_dec #(
    parameter int DATA_WIDTH   = 160,
    parameter int PARITY_WIDTH = 9
) (
    input  logic                    bypass,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    output logic [DATA_WIDTH-1:0]   mask,
    output logic                    sbit_err,
    output logic                    dbit_err
);
    localparam int SYN_W = PARITY_WIDTH - 1;

    // Hamming position of data bit idx: the idx-th non-power-of-two position from 3 up.
    function automatic int data_pos(input int idx);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int p = 3; p < (1 << SYN_W); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) pos = p;
                n++;
            end
        end
        return pos;
    endfunction

    logic [SYN_W-1:0] contrib [DATA_WIDTH];
    logic [SYN_W-1:0] syndrome;
    logic             overall;

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bit
        localparam int P = data_pos(g);
        assign contrib[g] = data_in[g] ? SYN_W'(P) : '0;
        assign mask[g]    = ~bypass & sbit_err & (syndrome == SYN_W'(P));
    end

    always_comb begin
        syndrome = parity_in[SYN_W-1:0];
        for (int i = 0; i < DATA_WIDTH; i++) begin
            syndrome = syndrome ^ contrib[i];
        end
        overall  = (^data_in) ^ (^parity_in);
        // Odd overall parity means one flipped bit; even parity with a syndrome means two.
        sbit_err = overall;
        dbit_err = ~overall & (|syndrome);
    end
endmodule

module ecc_lockstep_checker #(
    parameter int DATA_WIDTH   = 160,
    parameter int PARITY_WIDTH = 9,
    parameter int CNT_WIDTH    = 8,
    parameter int FAULT_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fault_detc_en,
    input  logic                    bypass,
    input  logic                    in_vld,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    output logic                    out_vld,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    sbit_err,
    output logic                    dbit_err,
    output logic                    ecc_fault,
    output logic                    fault_sticky,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    output logic                    fault_alarm,
    input  logic                    fault_clr,
    input  logic                    selftest_req,
    output logic                    selftest_busy,
    output logic                    selftest_done,
    output logic                    selftest_pass
);
    localparam int                   CMP_W   = DATA_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] THRESH  = CNT_WIDTH'(FAULT_THRESH);

    typedef enum logic [1:0] {ST_IDLE, ST_INJ, ST_RPT} st_t;

    logic [DATA_WIDTH-1:0] mask_0;
    logic [DATA_WIDTH-1:0] mask_1;
    logic                  sbit_0, dbit_0, sbit_1, dbit_1;
    logic [CMP_W-1:0]      cmp_vec_0, cmp_vec_1;
    logic [DATA_WIDTH-1:0] corrected_0;
    logic                  mism, mism_inj, fault_ev;
    st_t                   state_q, state_d;

    ecc_secded_dec #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec0 (
        .bypass(bypass), .data_in(data_in), .parity_in(parity_in),
        .mask(mask_0), .sbit_err(sbit_0), .dbit_err(dbit_0)
    );

    ecc_secded_dec #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec1 (
        .bypass(bypass), .data_in(data_in), .parity_in(parity_in),
        .mask(mask_1), .sbit_err(sbit_1), .dbit_err(dbit_1)
    );

    // The self-test path flips bit 0 of the second vector only; it never feeds fault_ev.
    assign cmp_vec_0   = {sbit_0, dbit_0, mask_0};
    assign cmp_vec_1   = {sbit_1, dbit_1, mask_1};
    assign mism        = |(cmp_vec_0 ^ cmp_vec_1);
    assign mism_inj    = |(cmp_vec_0 ^ (cmp_vec_1 ^ CMP_W'(1)));
    assign corrected_0 = data_in ^ mask_0;
    assign fault_ev    = in_vld & fault_detc_en & mism;

    // Output register stage (latency 1)
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            data_out  <= '0;
            sbit_err  <= 1'b0;
            dbit_err  <= 1'b0;
            ecc_fault <= 1'b0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                data_out  <= (mism & fault_detc_en) ? data_in : corrected_0;
                sbit_err  <= sbit_0;
                dbit_err  <= dbit_0;
                ecc_fault <= mism & fault_detc_en;
            end else begin
                sbit_err  <= 1'b0;
                dbit_err  <= 1'b0;
                ecc_fault <= 1'b0;
            end
        end
    end

    // Fault bookkeeping; a clear coinciding with an event keeps that event.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_cnt    <= '0;
            fault_sticky <= 1'b0;
            fault_alarm  <= 1'b0;
        end else if (fault_clr) begin
            fault_cnt    <= fault_ev ? CNT_WIDTH'(1) : '0;
            fault_sticky <= fault_ev;
            fault_alarm  <= fault_ev & (FAULT_THRESH == 1);
        end else begin
            if (fault_ev) begin
                if (fault_cnt != CNT_MAX) fault_cnt <= fault_cnt + 1'b1;
                fault_sticky <= 1'b1;
            end
            fault_alarm <= fault_alarm | (fault_cnt >= THRESH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            selftest_pass <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INJ) selftest_pass <= mism_inj;
        end
    end

    always_comb begin
        state_d       = state_q;
        selftest_busy = 1'b0;
        selftest_done = 1'b0;
        case (state_q)
            ST_IDLE: if (selftest_req) state_d = ST_INJ;
            ST_INJ: begin
                selftest_busy = 1'b1;
                state_d       = ST_RPT;
            end
            ST_RPT: begin
                selftest_busy = 1'b1;
                selftest_done = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ecc_lockstep_checker.sv
// Directed bench for ecc_lockstep_checker: default instance plus a 2-bit-counter instance.

module tb_ecc_lockstep_checker;
    localparam int DW = 160;
    localparam int PW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fault_detc_en = 1'b0;
    logic          bypass = 1'b0;
    logic          in_vld = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [PW-1:0] parity_in = '0;
    logic          fault_clr = 1'b0;
    logic          fault_clr2 = 1'b0;
    logic          selftest_req = 1'b0;

    logic          out_vld, sbit_err, dbit_err, ecc_fault, fault_sticky, fault_alarm;
    logic [DW-1:0] data_out;
    logic [7:0]    fault_cnt;
    logic          selftest_busy, selftest_done, selftest_pass;

    logic          out_vld2, sbit2, dbit2, ecc_fault2, sticky2, alarm2, busy2, done2, pass2;
    logic [DW-1:0] data_out2;
    logic [1:0]    cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ecc_lockstep_checker dut (
        .clk(clk), .rst(rst), .fault_detc_en(fault_detc_en), .bypass(bypass),
        .in_vld(in_vld), .data_in(data_in), .parity_in(parity_in),
        .out_vld(out_vld), .data_out(data_out), .sbit_err(sbit_err), .dbit_err(dbit_err),
        .ecc_fault(ecc_fault), .fault_sticky(fault_sticky), .fault_cnt(fault_cnt),
        .fault_alarm(fault_alarm), .fault_clr(fault_clr), .selftest_req(selftest_req),
        .selftest_busy(selftest_busy), .selftest_done(selftest_done), .selftest_pass(selftest_pass)
    );

    ecc_lockstep_checker #(.CNT_WIDTH(2), .FAULT_THRESH(1)) dut2 (
        .clk(clk), .rst(rst), .fault_detc_en(fault_detc_en), .bypass(bypass),
        .in_vld(in_vld), .data_in(data_in), .parity_in(parity_in),
        .out_vld(out_vld2), .data_out(data_out2), .sbit_err(sbit2), .dbit_err(dbit2),
        .ecc_fault(ecc_fault2), .fault_sticky(sticky2), .fault_cnt(cnt2),
        .fault_alarm(alarm2), .fault_clr(fault_clr2), .selftest_req(1'b0),
        .selftest_busy(busy2), .selftest_done(done2), .selftest_pass(pass2)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder: 8 Hamming bits over non-power-of-two positions, bit 8 = overall even parity.
    function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
        logic [7:0] s;
        int         p;
        s = '0;
        p = 3;
        for (int i = 0; i < DW; i++) begin
            while ((p & (p - 1)) == 0) p++;
            if (d[i]) s = s ^ p[7:0];
            p++;
        end
        return {(^d) ^ (^s), s};
    endfunction

    logic [DW-1:0] word_a, b37, b90, b5;

    initial begin
        word_a = 160'h1234_5678_9abc_def0_0fed_cba9_8765_4321_dead_beef;
        b37    = '0; b37[37] = 1'b1;
        b90    = '0; b90[90] = 1'b1;
        b5     = '0; b5[5]   = 1'b1;

        step(); step();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_cnt", fault_cnt, 0);
        chk("rst_sticky", fault_sticky, 0);
        chk("rst_alarm", fault_alarm, 0);
        chk("rst_busy", selftest_busy, 0);
        chk("rst_pass", selftest_pass, 0);
        rst = 1'b0;

        // Clean word
        fault_detc_en = 1'b1; in_vld = 1'b1;
        data_in = word_a; parity_in = enc(word_a);
        step();
        chk("clean_vld", out_vld, 1);
        chk("clean_data", data_out, word_a);
        chk("clean_sbit", sbit_err, 0);
        chk("clean_dbit", dbit_err, 0);
        chk("clean_fault", ecc_fault, 0);

        // Single-bit error corrected
        data_in = word_a ^ b37;
        step();
        chk("sbe_data", data_out, word_a);
        chk("sbe_sbit", sbit_err, 1);
        chk("sbe_fault", ecc_fault, 0);
        chk("sbe_cnt", fault_cnt, 0);

        // Double-bit error detected, not corrected
        data_in = word_a ^ b37 ^ b90;
        step();
        chk("dbe_dbit", dbit_err, 1);
        chk("dbe_sbit", sbit_err, 0);
        chk("dbe_data", data_out, word_a ^ b37 ^ b90);

        // Decoder-1 mask disagrees with decoder-0: fallback to raw and count
        data_in = word_a ^ b37;
        force dut.mask_1 = b5;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("lock_fault", ecc_fault, 1);
            chk("lock_raw", data_out, word_a ^ b37);
            chk("lock_cnt", fault_cnt, DW'(k));
            chk("lock_sticky", fault_sticky, 1);
        end
        chk("alarm_not_yet", fault_alarm, 0);
        in_vld = 1'b0;
        step();
        chk("alarm_set", fault_alarm, 1);
        chk("idle_vld", out_vld, 0);
        chk("idle_fault", ecc_fault, 0);
        fault_detc_en = 1'b0; in_vld = 1'b1;
        step();
        chk("dis_fault", ecc_fault, 0);
        chk("dis_data", data_out, word_a);
        chk("dis_cnt", fault_cnt, 4);
        release dut.mask_1;

        // Self-test with idle input
        fault_detc_en = 1'b1; in_vld = 1'b0; selftest_req = 1'b1;
        step();
        selftest_req = 1'b0;
        chk("st_busy1", selftest_busy, 1);
        chk("st_done1", selftest_done, 0);
        step();
        chk("st_busy2", selftest_busy, 1);
        chk("st_done2", selftest_done, 1);
        chk("st_pass", selftest_pass, 1);
        chk("st_fault", ecc_fault, 0);
        chk("st_cnt", fault_cnt, 4);
        step();
        chk("st_busy3", selftest_busy, 0);
        chk("st_done3", selftest_done, 0);
        chk("st_pass_hold", selftest_pass, 1);

        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("clr_cnt", fault_cnt, 0);
        chk("clr_sticky", fault_sticky, 0);
        chk("clr_alarm", fault_alarm, 0);

        // Saturation on the 2-bit counter instance
        in_vld = 1'b1;
        force dut2.mask_1 = b5;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("sat_cnt", cnt2, DW'((k > 3) ? 3 : k));
        end
        chk("sat_fault", ecc_fault2, 1);
        chk("sat_vld", out_vld2, 1);
        chk("sat_raw", data_out2, word_a ^ b37);
        chk("sat_sbit", sbit2, 1);
        chk("sat_dbit", dbit2, 0);
        chk("sat_alarm", alarm2, 1);
        chk("sat_busy", busy2 | done2 | pass2, 0);
        chk("sat_dut1_cnt", fault_cnt, 0);
        fault_clr2 = 1'b1;
        step();
        chk("clrev_cnt", cnt2, 1);
        chk("clrev_sticky", sticky2, 1);
        chk("clrev_alarm", alarm2, 1);
        in_vld = 1'b0;
        step();
        fault_clr2 = 1'b0;
        chk("clr2_cnt", cnt2, 0);
        chk("clr2_sticky", sticky2, 0);
        chk("clr2_alarm", alarm2, 0);
        release dut2.mask_1;

        // Reset during INJ
        selftest_req = 1'b1; in_vld = 1'b1;
        step();
        selftest_req = 1'b0;
        chk("inj_busy", selftest_busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; in_vld = 1'b0;
        chk("rinj_busy", selftest_busy, 0);
        chk("rinj_done", selftest_done, 0);
        chk("rinj_pass", selftest_pass, 0);
        chk("rinj_vld", out_vld, 0);
        chk("rinj_data", data_out, 0);
        selftest_req = 1'b1;
        step();
        selftest_req = 1'b0;
        step();
        chk("re_done", selftest_done, 1);
        chk("re_pass", selftest_pass, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
